phy_init_seq: RTL and testbench



---
 rtl/phy_init_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_phy_init_seq.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_init_seq.sv
// -----------------------------------------------------------------------------
// phy_init_seq
//
// PHY initialisation sequencer and CSR-bus arbiter (clk_sys domain).
// Replays an external table of CSR operations (END / WRITE / WAIT / POLL) into
// the DDR PHY core CSR port. While the table runs the engine owns the CSR bus
// and the host sees busy. Otherwise the host path is a zero-latency
// combinational pass-through.
//
// Ports:
//   clk_sys, rst_sys      : clock, asynchronous active-high reset
//   start                 : one-cycle pulse, re-run table from entry 0
//   tbl_addr              : table index (table read is combinational)
//   tbl_op/adr/data/mask  : current table entry
//   host_we/addr/wdata    : host CSR request from the register adapter
//   host_rdata            : host read data (= csr_dat_r)
//   host_busy             : engine owns the bus
//   csr_adr/we/dat_w      : PHY core CSR request
//   csr_dat_r             : PHY core read data, valid 1 cycle after csr_adr
//   init_done, init_error : sticky completion / poll-timeout flags
//   err_idx               : table index of the POLL entry that timed out
// -----------------------------------------------------------------------------
module phy_init_seq #(
  parameter int TblAw       = 6,
  parameter int PollTimeout = 1024,
  parameter bit AutoStart   = 1'b1
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             start,
  output logic [TblAw-1:0] tbl_addr,
  input  logic [1:0]       tbl_op,
  input  logic [9:0]       tbl_adr,
  input  logic [31:0]      tbl_data,
  input  logic [31:0]      tbl_mask,
  input  logic             host_we,
  input  logic [9:0]       host_addr,
  input  logic [31:0]      host_wdata,
  output logic [31:0]      host_rdata,
  output logic             host_busy,
  output logic [9:0]       csr_adr,
  output logic             csr_we,
  output logic [31:0]      csr_dat_w,
  input  logic [31:0]      csr_dat_r,
  output logic             init_done,
  output logic             init_error,
  output logic [TblAw-1:0] err_idx
);

  localparam int AttW = $clog2(PollTimeout + 1);
  localparam logic [TblAw-1:0] IdxMax = {TblAw{1'b1}};
  localparam logic [AttW-1:0]  AttMax = AttW'(PollTimeout);

  localparam logic [1:0] OpEnd   = 2'd0;
  localparam logic [1:0] OpWrite = 2'd1;
  localparam logic [1:0] OpWait  = 2'd2;
  localparam logic [1:0] OpPoll  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_WAIT,
    S_POLL_ADR,
    S_POLL_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  // With AutoStart the engine already sits in FETCH while reset is held, so
  // the first cycle after release fetches entry 0 and host_busy is high.
  localparam state_t RstState = AutoStart ? S_FETCH : S_IDLE;

  state_t            state_q, state_d;
  logic [TblAw-1:0]  idx_q, idx_d;
  logic [9:0]        adr_q, adr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       mask_q, mask_d;
  logic [31:0]       wait_q, wait_d;
  logic [AttW-1:0]   att_q, att_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [TblAw-1:0]  err_idx_q, err_idx_d;

  logic              advance;
  logic              poll_match;
  logic [AttW-1:0]   att_inc;

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q   <= RstState;
      idx_q     <= '0;
      adr_q     <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      wait_q    <= '0;
      att_q     <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      adr_q     <= adr_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      wait_q    <= wait_d;
      att_q     <= att_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign poll_match = ((csr_dat_r & mask_q) == (data_q & mask_q));
  assign att_inc    = att_q + AttW'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    adr_d     = adr_q;
    data_d    = data_q;
    mask_d    = mask_q;
    wait_d    = wait_q;
    att_d     = att_q;
    done_d    = done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    advance   = 1'b0;

    // Engine owns the bus unless one of the host states below overrides.
    host_busy = 1'b1;
    csr_adr   = '0;
    csr_we    = 1'b0;
    csr_dat_w = '0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        // Host write in the same cycle as start is still forwarded here.
        host_busy = 1'b0;
        csr_adr   = host_addr;
        csr_we    = host_we;
        csr_dat_w = host_wdata;
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
          att_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end

      S_FETCH: begin
        adr_d  = tbl_adr;
        data_d = tbl_data;
        mask_d = tbl_mask;
        att_d  = '0;
        case (tbl_op)
          OpEnd: begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
          OpWrite: state_d = S_WRITE;
          OpWait: begin
            state_d = S_WAIT;
            wait_d  = tbl_data;
          end
          OpPoll:  state_d = S_POLL_ADR;
          default: state_d = S_DONE;
        endcase
      end

      S_WRITE: begin
        csr_adr   = adr_q;
        csr_we    = 1'b1;
        csr_dat_w = data_q;
        advance   = 1'b1;
      end

      S_WAIT: begin
        if (wait_q == 32'd0) begin
          advance = 1'b1;
        end else begin
          wait_d = wait_q - 32'd1;
        end
      end

      S_POLL_ADR: begin
        // Read address goes out here; the PHY answers during POLL_CHK.
        csr_adr = adr_q;
        state_d = S_POLL_CHK;
      end

      S_POLL_CHK: begin
        if (poll_match) begin
          att_d   = '0;
          advance = 1'b1;
        end else if (att_inc == AttMax) begin
          att_d     = att_inc;
          state_d   = S_ERROR;
          error_d   = 1'b1;
          err_idx_d = idx_q;
        end else begin
          att_d   = att_inc;
          state_d = S_POLL_ADR;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Entry finished: step to the next one, or treat the end of the table
    // as an implicit END because the index does not wrap.
    if (advance) begin
      if (idx_q == IdxMax) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        idx_d   = idx_q + TblAw'(1);
        state_d = S_FETCH;
      end
    end
  end

  assign tbl_addr   = idx_q;
  assign host_rdata = csr_dat_r;
  assign init_done  = done_q;
  assign init_error = error_q;
  assign err_idx    = err_idx_q;

endmodule

// File: tb/tb_phy_init_seq.sv
// -----------------------------------------------------------------------------
// tb_phy_init_seq
//
// Scoreboard bench for phy_init_seq. The driver loads a table, computes the
// expected CSR writes and completion event of the whole run from the entry
// timing rules (FETCH+WRITE = 2, WAIT N = N+2, POLL = 1+2k) and queues them.
// A negedge monitor pops and compares whenever the DUT shows a CSR write or a
// rising init_done / init_error. A small PHY model answers POLL reads: poll
// entry i lives at CSR address 0x020+i and matches on its succ[i]-th read
// (0 = never).
// -----------------------------------------------------------------------------
module tb_phy_init_seq;

  localparam int AW = 6;
  localparam int NE = 64;
  localparam int PT = 4;

  localparam int K_W    = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic          clk_sys = 1'b0;
  logic          rst_sys = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] tbl_addr;
  logic [1:0]    tbl_op;
  logic [9:0]    tbl_adr;
  logic [31:0]   tbl_data;
  logic [31:0]   tbl_mask;
  logic          host_we = 1'b0;
  logic [9:0]    host_addr = '0;
  logic [31:0]   host_wdata = '0;
  logic [31:0]   host_rdata;
  logic          host_busy;
  logic [9:0]    csr_adr;
  logic          csr_we;
  logic [31:0]   csr_dat_w;
  logic [31:0]   csr_dat_r = '0;
  logic          init_done;
  logic          init_error;
  logic [AW-1:0] err_idx;

  always #5 clk_sys = ~clk_sys;

  phy_init_seq #(.TblAw(AW), .PollTimeout(PT), .AutoStart(1'b1)) dut (
    .clk_sys    (clk_sys),
    .rst_sys    (rst_sys),
    .start      (start),
    .tbl_addr   (tbl_addr),
    .tbl_op     (tbl_op),
    .tbl_adr    (tbl_adr),
    .tbl_data   (tbl_data),
    .tbl_mask   (tbl_mask),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_busy  (host_busy),
    .csr_adr    (csr_adr),
    .csr_we     (csr_we),
    .csr_dat_w  (csr_dat_w),
    .csr_dat_r  (csr_dat_r),
    .init_done  (init_done),
    .init_error (init_error),
    .err_idx    (err_idx)
  );

  // ---------------- table ----------------
  logic [1:0]  t_op   [NE];
  logic [9:0]  t_adr  [NE];
  logic [31:0] t_data [NE];
  logic [31:0] t_mask [NE];
  int          succ   [NE];

  assign tbl_op   = t_op[tbl_addr];
  assign tbl_adr  = t_adr[tbl_addr];
  assign tbl_data = t_data[tbl_addr];
  assign tbl_mask = t_mask[tbl_addr];

  // ---------------- bookkeeping ----------------
  typedef struct {
    int          kind;
    logic [9:0]  adr;
    logic [31:0] data;
    int          cyc;
    bit          chk_cyc;
  } ev_t;

  ev_t  exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   base = 0;
  logic phy_clr = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc - base);
    end
  endtask

  task automatic push_ev(input int kind, input logic [9:0] adr, input logic [31:0] data,
                         input int c, input bit chk_c);
    ev_t e;
    e.kind = kind; e.adr = adr; e.data = data; e.cyc = c; e.chk_cyc = chk_c;
    exp_q.push_back(e);
  endtask

  // ---------------- PHY model ----------------
  int rd_cnt [NE];
  always @(posedge clk_sys) begin : phy_model
    int          k;
    int          n;
    logic [31:0] lb;
    logic [31:0] r;
    r = $urandom;
    csr_dat_r <= r;
    if (rst_sys || phy_clr) begin
      for (int i = 0; i < NE; i++) rd_cnt[i] <= 0;
    end else if (!csr_we && host_busy && csr_adr >= 10'h020 && csr_adr < 10'h060) begin
      k = int'(csr_adr) - 32;
      if (t_op[k] == 2'd3 && t_adr[k] == csr_adr) begin
        n  = rd_cnt[k] + 1;
        rd_cnt[k] <= n;
        lb = t_mask[k] & (~t_mask[k] + 32'd1);
        if (succ[k] != 0 && n >= succ[k])
          csr_dat_r <= (t_data[k] & t_mask[k]) | (r & ~t_mask[k]);
        else
          csr_dat_r <= ((t_data[k] ^ lb) & t_mask[k]) | (r & ~t_mask[k]);
      end
    end
  end

  // ---------------- monitor ----------------
  bit done_p = 1'b0;
  bit err_p  = 1'b0;
  always @(negedge clk_sys) begin : monitor
    int  off;
    ev_t e;
    off = cyc - base;
    if (csr_we === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].kind != K_W) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: got adr %h data %h busy %b at cycle %0d, expected no write",
                 csr_adr, csr_dat_w, host_busy, off);
      end else begin
        e = exp_q.pop_front();
        chk("wr_adr", 32'(csr_adr), 32'(e.adr));
        chk("wr_data", csr_dat_w, e.data);
        if (e.chk_cyc) chk("wr_cycle", 32'(off), 32'(e.cyc));
      end
    end
    if (init_done === 1'b1 && !done_p) begin
      if (exp_q.size() == 0 || exp_q[0].kind != K_DONE) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: got init_done=1 at cycle %0d, expected other event", off);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", 32'(off), 32'(e.cyc));
        chk("done_busy", 32'(host_busy), 32'd0);
        chk("done_error", 32'(init_error), 32'd0);
      end
    end
    if (init_error === 1'b1 && !err_p) begin
      if (exp_q.size() == 0 || exp_q[0].kind != K_ERR) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_error: got init_error=1 idx %0d at cycle %0d, expected other event",
                 err_idx, off);
      end else begin
        e = exp_q.pop_front();
        chk("err_cycle", 32'(off), 32'(e.cyc));
        chk("err_idx", 32'(err_idx), e.data);
        chk("err_busy", 32'(host_busy), 32'd0);
        chk("err_done", 32'(init_done), 32'd0);
      end
    end
    done_p <= (init_done === 1'b1);
    err_p  <= (init_error === 1'b1);
  end

  // ---------------- reference model ----------------
  // Cycle 1 is the FETCH of entry 0; returns the cycle of the final event.
  task automatic model(output int e_end);
    int t;
    t = 1;
    e_end = 0;
    for (int i = 0; i < NE; i++) begin
      case (t_op[i])
        2'd0: begin
          push_ev(K_DONE, '0, '0, t + 1, 1'b1);
          e_end = t + 1;
          return;
        end
        2'd1: begin
          push_ev(K_W, t_adr[i], t_data[i], t + 1, 1'b1);
          t += 2;
        end
        2'd2: t += int'(t_data[i]) + 2;
        default: begin
          if (succ[i] != 0 && succ[i] <= PT) begin
            t += 1 + 2 * succ[i];
          end else begin
            push_ev(K_ERR, '0, 32'(i), t + 1 + 2 * PT, 1'b1);
            e_end = t + 1 + 2 * PT;
            return;
          end
        end
      endcase
      if (i == NE - 1) begin
        push_ev(K_DONE, '0, '0, t, 1'b1);
        e_end = t;
      end
    end
  endtask

  // ---------------- table builders ----------------
  task automatic clear_tbl();
    for (int i = 0; i < NE; i++) begin
      t_op[i] = 2'd0; t_adr[i] = '0; t_data[i] = '0; t_mask[i] = '0; succ[i] = 0;
    end
  endtask

  task automatic set_ent(input int i, input logic [1:0] op, input logic [9:0] adr,
                         input logic [31:0] data, input logic [31:0] mask, input int s);
    t_op[i] = op; t_adr[i] = adr; t_data[i] = data; t_mask[i] = mask; succ[i] = s;
  endtask

  task automatic rand_tbl(input int len, input bit allow_err);
    logic [31:0] m;
    clear_tbl();
    for (int i = 0; i < len; i++) begin
      case ($urandom_range(1, 3))
        1: set_ent(i, 2'd1, 10'($urandom), $urandom, '0, 0);
        2: set_ent(i, 2'd2, '0, 32'($urandom_range(0, 6)), '0, 0);
        default: begin
          m = $urandom;
          if (m == 32'd0) m = 32'd1;
          set_ent(i, 2'd3, 10'(32 + i), $urandom, m,
                  (allow_err && $urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, PT)));
        end
      endcase
    end
  endtask

  // ---------------- run driver ----------------
  task automatic run_loop(input int e_end, input bit noise);
    int guard;
    int o;
    guard = 0;
    while (exp_q.size() != 0 && guard < e_end + 50) begin
      @(posedge clk_sys); #1;
      guard++;
      o = cyc - base;
      phy_clr = 1'b0;
      host_we = 1'b0;
      start   = 1'b0;
      if (o >= 1 && o < e_end) begin
        chk("busy_run", 32'(host_busy), 32'd1);
        if (noise) begin
          host_we    = ($urandom_range(0, 3) == 0);
          host_addr  = 10'($urandom);
          host_wdata = $urandom;
          start      = ($urandom_range(0, 15) == 0);
        end
      end
    end
    host_we = 1'b0;
    start   = 1'b0;
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout: got %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic launch(input bit host_wr, input bit noise);
    int e;
    @(posedge clk_sys); #1;
    if (host_wr) begin
      host_addr  = 10'($urandom);
      host_wdata = $urandom;
      host_we    = 1'b1;
      push_ev(K_W, host_addr, host_wdata, 0, 1'b0);
    end
    model(e);
    phy_clr = 1'b1;
    start   = 1'b1;
    base    = cyc;
    run_loop(e, noise);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_csr_we"}, 32'(csr_we), 32'd0);
    chk({tag, "_csr_adr"}, 32'(csr_adr), 32'd0);
    chk({tag, "_csr_dat_w"}, csr_dat_w, 32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_init_error"}, 32'(init_error), 32'd0);
    chk({tag, "_err_idx"}, 32'(err_idx), 32'd0);
    chk({tag, "_tbl_addr"}, 32'(tbl_addr), 32'd0);
    chk({tag, "_host_busy"}, 32'(host_busy), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int e;

    // AutoStart boot: WRITE 0x010<-0xA5, WRITE 0x014<-0x1, END.
    clear_tbl();
    set_ent(0, 2'd1, 10'h010, 32'h0000_00A5, '0, 0);
    set_ent(1, 2'd1, 10'h014, 32'h0000_0001, '0, 0);
    repeat (3) @(posedge clk_sys);
    #1;
    chk_reset_outputs("reset");
    model(e);
    rst_sys = 1'b0;
    base = cyc - 1;
    run_loop(e, 1'b0);

    // Host write after DONE is forwarded in the same cycle.
    host_addr  = 10'h030;
    host_wdata = 32'h0000_DEAD;
    host_we    = 1'b1;
    push_ev(K_W, 10'h030, 32'h0000_DEAD, 0, 1'b0);
    @(posedge clk_sys); #1;
    host_we = 1'b0;
    chk("host_fwd_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // WAIT 5 and WAIT 0 between writes.
    clear_tbl();
    set_ent(0, 2'd1, 10'h100, 32'h1, '0, 0);
    set_ent(1, 2'd2, '0, 32'd5, '0, 0);
    set_ent(2, 2'd1, 10'h104, 32'h2, '0, 0);
    set_ent(3, 2'd2, '0, 32'd0, '0, 0);
    set_ent(4, 2'd1, 10'h108, 32'h3, '0, 0);
    launch(1'b0, 1'b1);

    // POLL success on the 3rd read, with start + host write in one cycle.
    clear_tbl();
    set_ent(0, 2'd3, 10'h020, 32'h1, 32'h1, 3);
    set_ent(1, 2'd1, 10'h110, 32'h7, '0, 0);
    launch(1'b1, 1'b1);

    // POLL timeout at index 2.
    clear_tbl();
    set_ent(0, 2'd1, 10'h200, 32'hA, '0, 0);
    set_ent(1, 2'd2, '0, 32'd2, '0, 0);
    set_ent(2, 2'd3, 10'h022, 32'h8, 32'hC, 0);
    launch(1'b0, 1'b1);

    // Reset asserted in POLL_CHK, then the run restarts at index 0.
    clear_tbl();
    set_ent(0, 2'd1, 10'h120, 32'h55, '0, 0);
    set_ent(1, 2'd3, 10'h021, 32'h3, 32'h3, 0);
    @(posedge clk_sys); #1;
    model(e);
    phy_clr = 1'b1;
    start   = 1'b1;
    base    = cyc;
    for (int i = 0; i < 20 && (cyc - base) != 5; i++) begin
      @(posedge clk_sys); #1;
      phy_clr = 1'b0;
      start   = 1'b0;
    end
    chk("mid_poll_pending", 32'(exp_q.size()), 32'd1);
    rst_sys = 1'b1;
    #1;
    chk_reset_outputs("rst_mid_poll");
    exp_q.delete();
    succ[1] = 2;
    @(posedge clk_sys); #1;
    model(e);
    rst_sys = 1'b0;
    base = cyc - 1;
    run_loop(e, 1'b1);

    // Full table with no END: completes at the saturated last index.
    rand_tbl(NE, 1'b0);
    launch(1'b0, 1'b1);

    // Randomised tables.
    for (int r = 0; r < 25; r++) begin
      rand_tbl(int'($urandom_range(1, 12)), 1'b1);
      launch(1'($urandom_range(0, 1)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
